// File: rtl/conv_y_collector_if.sv
// Sample stream between a convolution layer's Y output and its collector.
interface conv_y_collector_if #(
  parameter int T = 16
);
  logic signed [T-1:0] s_data_in_y;
  logic                s_valid_y;
  logic                s_ready_y;

  modport master (output s_data_in_y, output s_valid_y, input s_ready_y);
  modport slave  (input s_data_in_y, input s_valid_y, output s_ready_y);
endinterface

// File: rtl/conv_y_collector.sv
// Collects one Y_COUNT-sample convolution output vector, tracks sum/max,
// and serves the captured vector through a registered read port.
//
// state   | meaning
// COLLECT | accepting samples; optional alternating backpressure
// FULL    | vector complete; input stalled, read port active
module conv_y_collector #(
  parameter int T       = 16,
  parameter int Y_COUNT = 29,
  parameter int ADDR_Y  = $clog2(Y_COUNT),
  parameter int S_W     = T + ADDR_Y
) (
  input  logic                     clk,
  input  logic                     reset,
  conv_y_collector_if.slave        y_if,
  input  logic                     stall_en,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic [ADDR_Y-1:0]        rd_addr,
  output logic signed [T-1:0]      rd_data,
  output logic                     rd_valid,
  output logic                     done,
  output logic [ADDR_Y:0]          count_y,
  output logic signed [S_W-1:0]    sum_y,
  output logic signed [T-1:0]      max_y
);

  localparam logic [ADDR_Y-1:0]   LAST_PTR = ADDR_Y'(Y_COUNT - 1);
  localparam logic [ADDR_Y:0]     Y_LEN    = (ADDR_Y + 1)'(Y_COUNT);
  localparam logic signed [T-1:0] MAX_INIT = {1'b1, {(T - 1){1'b0}}};

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                state;
  logic                  phase;
  logic [ADDR_Y-1:0]     wr_ptr;
  logic signed [T-1:0]   mem [Y_COUNT];
  logic signed [T-1:0]   din;
  logic                  ready;
  logic                  beat;

  assign din  = y_if.s_data_in_y;
  // clear and reset both gate ready so a beat is never half-accepted
  assign ready = (state == COLLECT) && !clear && !reset && (!stall_en || !phase);
  assign y_if.s_ready_y = ready;
  assign beat = y_if.s_valid_y && ready;

  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      phase    <= 1'b0;
      wr_ptr   <= '0;
      done     <= 1'b0;
      count_y  <= '0;
      sum_y    <= '0;
      max_y    <= MAX_INIT;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      // a read coinciding with clear still sees the old vector
      if (rd_en && state == FULL) begin
        rd_valid <= 1'b1;
        rd_data  <= ({1'b0, rd_addr} < Y_LEN) ? mem[rd_addr] : '0;
      end else begin
        rd_valid <= 1'b0;
      end

      if (clear) begin
        state   <= COLLECT;
        phase   <= 1'b0;
        wr_ptr  <= '0;
        done    <= 1'b0;
        count_y <= '0;
        sum_y   <= '0;
        max_y   <= MAX_INIT;
      end else begin
        case (state)
          COLLECT: begin
            phase <= stall_en ? ~phase : 1'b0;
            if (beat) begin
              wr_ptr  <= wr_ptr + ADDR_Y'(1);
              count_y <= count_y + (ADDR_Y + 1)'(1);
              sum_y   <= sum_y + S_W'(din);
              if (din > max_y) max_y <= din;
              if (wr_ptr == LAST_PTR) begin
                state <= FULL;
                done  <= 1'b1;
              end
            end
          end
          FULL: phase <= 1'b0;
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_y_collector.sv
// Directed test of conv_y_collector: stimulus pushes expected read data into
// a queue which a negedge monitor drains whenever rd_valid is presented.
module tb_conv_y_collector;
  localparam int T  = 16;
  localparam int Y  = 29;
  localparam int A  = 5;
  localparam int SW = T + A;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall_en = 1'b0;
  logic clear = 1'b0;
  logic rd_en = 1'b0;
  logic [A-1:0] rd_addr = '0;
  logic signed [T-1:0] rd_data;
  logic rd_valid;
  logic done;
  logic [A:0] count_y;
  logic signed [SW-1:0] sum_y;
  logic signed [T-1:0] max_y;

  conv_y_collector_if #(.T(T)) y_if ();

  conv_y_collector #(.T(T), .Y_COUNT(Y)) dut (
    .clk(clk), .reset(reset), .y_if(y_if), .stall_en(stall_en), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .count_y(count_y), .sum_y(sum_y), .max_y(max_y)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic signed [T-1:0] rd_q[$];
  logic signed [T-1:0] mon_exp;
  logic signed [T-1:0] stim[Y];
  logic signed [T-1:0] model_mem[Y];
  int m_ptr, m_count, m_max, total;
  longint m_sum;

  // read-data monitor
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%0d, required no read pending", rd_data);
      end else begin
        mon_exp = rd_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_fail++;
          $display("FAIL rd_data: got %0d required %0d", rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0; m_count = 0; m_sum = 0; m_max = -32768;
  endtask

  task automatic model_push(input logic signed [T-1:0] d);
    model_mem[m_ptr] = d;
    m_ptr++;
    m_count++;
    m_sum += d;
    if (int'(d) > m_max) m_max = d;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, count_y, m_count);
    chk({tag, "_sum"}, sum_y, m_sum);
    chk({tag, "_max"}, max_y, m_max);
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < Y; i++) stim[i] = T'(base + i);
  endtask

  task automatic send_beat(input logic signed [T-1:0] d, output int cyc);
    bit acc;
    acc = 1'b0;
    cyc = 0;
    y_if.s_data_in_y = d;
    y_if.s_valid_y = 1'b1;
    while (!acc && cyc < 8) begin
      @(negedge clk);
      acc = (y_if.s_ready_y === 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    if (acc) model_push(d);
    else begin
      n_chk++; n_fail++;
      $display("FAIL beat_timeout: no ready within %0d cycles, required accept", cyc);
    end
  endtask

  task automatic send_vec(input int n, output int tot);
    int c;
    tot = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(stim[i], c);
      tot += c;
    end
  endtask

  task automatic do_read(input int addr, input logic signed [T-1:0] exp);
    rd_en = 1'b1;
    rd_addr = A'(addr);
    rd_q.push_back(exp);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    y_if.s_data_in_y = '0;
    y_if.s_valid_y = 1'b0;
    model_clear();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", y_if.s_ready_y, 0);
    chk("rst_count", count_y, 0);
    chk("rst_sum", sum_y, 0);
    chk("rst_max", max_y, -32768);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", y_if.s_ready_y, 1);
    @(posedge clk); #1;

    // continuous ramp 1..29
    fill_ramp(1);
    send_vec(Y, total);
    y_if.s_valid_y = 1'b0;
    chk("cont_cycles", total, 29);
    chk("cont_done", done, 1);
    chk("cont_count", count_y, 29);
    chk("cont_sum", sum_y, 435);
    chk("cont_max", max_y, 29);
    chk("cont_ready_full", y_if.s_ready_y, 0);
    do_read(5, 16'sd6);
    do_read(0, 16'sd1);
    do_read(28, 16'sd29);
    do_read(31, 16'sd0);

    // read together with clear, then read in COLLECT
    rd_en = 1'b1; rd_addr = 5'd3; clear = 1'b1;
    rd_q.push_back(16'sd4);
    @(posedge clk); #1;
    rd_en = 1'b0; clear = 1'b0;
    model_clear();
    chk("clr_done", done, 0);
    check_status("clr");
    rd_en = 1'b1; rd_addr = 5'd2;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("collect_rd_valid", rd_valid, 0);
    chk("collect_rd_hold", rd_data, 4);

    // alternating backpressure
    stall_en = 1'b1;
    fill_ramp(1);
    send_vec(Y, total);
    y_if.s_valid_y = 1'b0;
    stall_en = 1'b0;
    chk("stall_cycles", total, 57);
    chk("stall_sum", sum_y, 435);
    chk("stall_done", done, 1);
    for (int i = 0; i < Y; i++) begin
      rd_en = 1'b1;
      rd_addr = A'(i);
      rd_q.push_back(model_mem[i]);
      @(posedge clk); #1;
    end
    rd_en = 1'b0;

    // signed data with valid gaps
    do_clear();
    for (int i = 0; i < Y; i++) stim[i] = '0;
    stim[0] = -16'sd5;
    stim[1] = 16'sd7;
    stim[2] = -16'sd32768;
    stim[3] = 16'sd32767;
    for (int i = 0; i < Y; i++) begin
      int c;
      if (i % 3 == 2) begin
        y_if.s_valid_y = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      send_beat(stim[i], c);
      if (i < 4) check_status($sformatf("gap_b%0d", i));
    end
    chk("gap_sum", sum_y, 1);
    chk("gap_max", max_y, 32767);
    chk("gap_done", done, 1);
    y_if.s_data_in_y = 16'sd1234;
    y_if.s_valid_y = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("full_ready", y_if.s_ready_y, 0);
      @(posedge clk); #1;
    end
    y_if.s_valid_y = 1'b0;
    chk("full_count", count_y, 29);
    chk("full_sum", sum_y, 1);
    do_read(2, -16'sd32768);
    do_read(3, 16'sd32767);
    do_read(31, 16'sd0);

    // clear mid-vector with valid high
    do_clear();
    fill_ramp(1);
    send_vec(10, total);
    chk("pre_clear_count", count_y, 10);
    y_if.s_data_in_y = 16'sd99;
    clear = 1'b1;
    #1;
    chk("clear_ready", y_if.s_ready_y, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    check_status("midclr");
    fill_ramp(100);
    send_vec(Y, total);
    y_if.s_valid_y = 1'b0;
    chk("midclr_cycles", total, 29);
    chk("midclr_sum", sum_y, 3306);
    chk("midclr_max", max_y, 128);
    do_read(0, 16'sd100);
    do_read(10, 16'sd110);

    // async reset at beat 14
    do_clear();
    fill_ramp(1);
    send_vec(14, total);
    #2;
    reset = 1'b1;
    #1;
    y_if.s_valid_y = 1'b0;
    chk("arst_count", count_y, 0);
    chk("arst_sum", sum_y, 0);
    chk("arst_max", max_y, -32768);
    chk("arst_ready", y_if.s_ready_y, 0);
    chk("arst_rd_data", rd_data, 0);
    y_if.s_valid_y = 1'b1;
    @(posedge clk); #1;
    chk("arst_hold_count", count_y, 0);
    y_if.s_valid_y = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_rel_ready", y_if.s_ready_y, 1);
    model_clear();
    @(posedge clk); #1;
    fill_ramp(201);
    send_vec(Y, total);
    y_if.s_valid_y = 1'b0;
    chk("arst_vec_cycles", total, 29);
    chk("arst_vec_sum", sum_y, 6235);
    check_status("arst_vec");
    do_read(13, 16'sd214);
    do_read(28, 16'sd229);

    repeat (5) @(posedge clk);
    #1;
    chk("done_sticky", done, 1);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
